// File: rtl/countdown_display_mux.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_display_mux
//  Description : Display side of the countdown timer. Captures binary
//                hour/minute/second on a load strobe, converts each field to
//                BCD by repeated subtraction (one step per clock), then drives
//                a 6-digit multiplexed 7-segment display (HH MM SS) with
//                optional leading-zero blanking and blinking when finished.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1  system clock
//    reset     in   1  synchronous, active-high reset
//    load      in   1  one-cycle strobe, captures hour/minute/second when idle
//    hour      in   6  binary hours   0..63
//    minute    in   6  binary minutes 0..63
//    second    in   6  binary seconds 0..63
//    finished  in   1  countdown reached zero
//    blink_en  in   1  enable blinking while finished=1
//    busy      out  1  BCD conversion in progress
//    seg       out  7  segments {g,f,e,d,c,b,a}, registered
//    dig_en    out  6  digit enables, bit0=sec units .. bit5=hour tens, registered
// ============================================================================
module countdown_display_mux #(
  parameter int SCAN_DIV         = 50000,
  parameter int BLINK_DIV        = 25000000,
  parameter bit SEG_ACTIVE_LOW   = 1'b0,
  parameter bit DIGIT_ACTIVE_LOW = 1'b0,
  parameter bit LZB              = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic       finished,
  input  logic       blink_en,
  output logic       busy,
  output logic [6:0] seg,
  output logic [5:0] dig_en
);

  localparam int c_SCAN_W  = $clog2(SCAN_DIV);
  localparam int c_BLINK_W = $clog2(BLINK_DIV);
  localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);
  localparam logic [6:0] c_SEG_INV = {7{SEG_ACTIVE_LOW}};
  localparam logic [5:0] c_DIG_INV = {6{DIGIT_ACTIVE_LOW}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV_S = 3'd1,
    ST_CONV_M = 3'd2,
    ST_CONV_H = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  // Conversion working registers and BCD results
  logic [5:0] r_work_s, r_work_m, r_work_h;
  logic [3:0] r_ten_s, r_ten_m, r_ten_h;
  logic [3:0] r_one_s, r_one_m, r_one_h;

  // Display registers, updated atomically in COMMIT
  logic [3:0] r_disp_s1, r_disp_s10, r_disp_m1, r_disp_m10, r_disp_h1, r_disp_h10;

  // Scan / blink
  logic [c_SCAN_W-1:0]  r_scan_cnt;
  logic [2:0]           r_idx;
  logic [c_BLINK_W-1:0] r_blink_cnt;
  logic                 r_phase_on;

  // Output registers
  logic [6:0] r_seg;
  logic [5:0] r_dig_en;

  logic [3:0] w_digit;
  logic [6:0] w_seg_dec;
  logic       w_blank;
  logic [6:0] w_seg_act;
  logic [5:0] w_dig_act;

  // --------------------------------------------------------------------------
  // Conversion FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (load)              w_state_nxt = ST_CONV_S;
      ST_CONV_S: if (r_work_s < 6'd10)  w_state_nxt = ST_CONV_M;
      ST_CONV_M: if (r_work_m < 6'd10)  w_state_nxt = ST_CONV_H;
      ST_CONV_H: if (r_work_h < 6'd10)  w_state_nxt = ST_COMMIT;
      ST_COMMIT:                        w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_work_s <= '0; r_work_m <= '0; r_work_h <= '0;
      r_ten_s  <= '0; r_ten_m  <= '0; r_ten_h  <= '0;
      r_one_s  <= '0; r_one_m  <= '0; r_one_h  <= '0;
      r_disp_s1 <= '0; r_disp_s10 <= '0;
      r_disp_m1 <= '0; r_disp_m10 <= '0;
      r_disp_h1 <= '0; r_disp_h10 <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_work_s <= second; r_work_m <= minute; r_work_h <= hour;
            r_ten_s  <= '0;     r_ten_m  <= '0;     r_ten_h  <= '0;
          end
        end
        ST_CONV_S: begin
          if (r_work_s >= 6'd10) begin
            r_work_s <= r_work_s - 6'd10;
            r_ten_s  <= r_ten_s + 4'd1;
          end else begin
            r_one_s  <= r_work_s[3:0];
          end
        end
        ST_CONV_M: begin
          if (r_work_m >= 6'd10) begin
            r_work_m <= r_work_m - 6'd10;
            r_ten_m  <= r_ten_m + 4'd1;
          end else begin
            r_one_m  <= r_work_m[3:0];
          end
        end
        ST_CONV_H: begin
          if (r_work_h >= 6'd10) begin
            r_work_h <= r_work_h - 6'd10;
            r_ten_h  <= r_ten_h + 4'd1;
          end else begin
            r_one_h  <= r_work_h[3:0];
          end
        end
        ST_COMMIT: begin
          r_disp_s1 <= r_one_s; r_disp_s10 <= r_ten_s;
          r_disp_m1 <= r_one_m; r_disp_m10 <= r_ten_m;
          r_disp_h1 <= r_one_h; r_disp_h10 <= r_ten_h;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Digit scan
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == c_SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Blink: only runs while finished and enabled; otherwise held lit and cleared
  // so each new blink episode starts with a full lit half-period.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || !(finished && blink_en)) begin
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
    end else if (r_blink_cnt == c_BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_phase_on  <= ~r_phase_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Digit select, decode and blanking
  // --------------------------------------------------------------------------
  always_comb begin
    w_digit = 4'd0;
    case (r_idx)
      3'd0:    w_digit = r_disp_s1;
      3'd1:    w_digit = r_disp_s10;
      3'd2:    w_digit = r_disp_m1;
      3'd3:    w_digit = r_disp_m10;
      3'd4:    w_digit = r_disp_h1;
      default: w_digit = r_disp_h10;
    endcase
  end

  always_comb begin
    w_seg_dec = 7'h00;
    case (w_digit)
      4'd0: w_seg_dec = 7'h3F;
      4'd1: w_seg_dec = 7'h06;
      4'd2: w_seg_dec = 7'h5B;
      4'd3: w_seg_dec = 7'h4F;
      4'd4: w_seg_dec = 7'h66;
      4'd5: w_seg_dec = 7'h6D;
      4'd6: w_seg_dec = 7'h7D;
      4'd7: w_seg_dec = 7'h07;
      4'd8: w_seg_dec = 7'h7F;
      4'd9: w_seg_dec = 7'h6F;
      default: w_seg_dec = 7'h00;
    endcase
  end

  always_comb begin
    w_blank   = (finished && blink_en && !r_phase_on) ||
                (LZB && (r_idx == 3'd5) && (r_disp_h10 == 4'd0));
    w_seg_act = w_blank ? 7'h00 : w_seg_dec;
    w_dig_act = w_blank ? 6'h00 : (6'b000001 << r_idx);
  end

  // Polarity is applied only here, at the pin-facing registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg    <= c_SEG_INV;
      r_dig_en <= c_DIG_INV;
    end else begin
      r_seg    <= w_seg_act ^ c_SEG_INV;
      r_dig_en <= w_dig_act ^ c_DIG_INV;
    end
  end

  assign seg    = r_seg;
  assign dig_en = r_dig_en;

endmodule
`default_nettype wire

// File: tb/tb_countdown_display_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_display_mux
//  Description : Self-checking bench for countdown_display_mux with a
//                cycle-level behavioural model of the display contents,
//                scan position, conversion latency and blink timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_countdown_display_mux;

  logic       clk;
  logic       reset;
  logic       load;
  logic [5:0] hour, minute, second;
  logic       finished, blink_en;
  logic       busy;
  logic [6:0] seg;
  logic [5:0] dig_en;

  countdown_display_mux #(
    .SCAN_DIV(4), .BLINK_DIV(16),
    .SEG_ACTIVE_LOW(1'b0), .DIGIT_ACTIVE_LOW(1'b0), .LZB(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .load(load),
    .hour(hour), .minute(minute), .second(second),
    .finished(finished), .blink_en(blink_en),
    .busy(busy), .seg(seg), .dig_en(dig_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  int ecyc = 0;        // edge counter
  int sc   = 0;        // edges since reset release
  int jb   = 0;        // consecutive edges with finished & blink_en
  int dh = 0, dm = 0, ds = 0;   // committed display values
  int ph, pm, ps;               // pending values
  bit pend = 0;
  int commit_e = 0;
  logic [6:0] exp_seg = '0;
  logic [5:0] exp_dig = '0;
  logic       exp_busy = 1'b0;

  function automatic logic [6:0] seg_code(input int d);
    logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (d >= 0 && d <= 9) ? t[d] : 7'h00;
  endfunction

  // Advance one clock and compute what the outputs must be afterwards
  task automatic tick();
    int idx, dig, h, m, s;
    bit blank;
    @(posedge clk);
    ecyc++;
    if (reset) begin
      sc = 0; jb = 0; dh = 0; dm = 0; ds = 0; pend = 0;
      exp_dig = '0; exp_seg = '0; exp_busy = 1'b0;
    end else begin
      idx = (sc / 4) % 6;
      case (idx)
        0: dig = ds % 10;
        1: dig = ds / 10;
        2: dig = dm % 10;
        3: dig = dm / 10;
        4: dig = dh % 10;
        default: dig = dh / 10;
      endcase
      blank = (finished && blink_en && ((jb / 16) % 2 == 1)) ||
              (idx == 5 && dh / 10 == 0);
      exp_dig = blank ? 6'h00 : 6'(1 << idx);
      exp_seg = blank ? 7'h00 : seg_code(dig);
      sc++;
      jb = (finished && blink_en) ? jb + 1 : 0;
      if (pend) begin
        if (ecyc == commit_e) begin
          dh = ph; dm = pm; ds = ps; pend = 0;
        end
      end else if (load) begin
        h = int'(hour); m = int'(minute); s = int'(second);
        ph = h; pm = m; ps = s; pend = 1;
        commit_e = ecyc + (h / 10 + 1) + (m / 10 + 1) + (s / 10 + 1) + 1;
      end
      exp_busy = pend;
    end
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    hour = 6'(h); minute = 6'(m); second = 6'(s);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dig_en !== 6'h00 || seg !== 7'h00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d dig_en=%b seg=%h busy=%b want 000000/00/0", ecyc, dig_en, seg, busy);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (dig_en !== 6'b000001 || seg !== 7'h3F) begin
      errors++;
      $display("FAIL reset_release dig_en=%b seg=%h want 000001/3f", dig_en, seg);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dig_en !== exp_dig || seg !== exp_seg || busy !== exp_busy) begin
        errors++;
        $display("FAIL reset_scan cyc=%0d dig_en=%b/%b seg=%h/%h busy=%b/%b", ecyc, dig_en, exp_dig, seg, exp_seg, busy, exp_busy);
      end
    end
    tick();
    checks++;
    if (dig_en !== 6'b000010) begin
      errors++;
      $display("FAIL reset_step dig_en=%b want 000010", dig_en);
    end
  endtask

  task automatic test_load_123456();
    logic [6:0] want [6] = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    logic [5:0] seen = '0;
    do_load(12, 34, 56);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL load_busy busy=%b want 1", busy);
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (dig_en !== exp_dig || seg !== exp_seg || busy !== exp_busy) begin
        errors++;
        $display("FAIL load_123456 cyc=%0d dig_en=%b/%b seg=%h/%h busy=%b/%b", ecyc, dig_en, exp_dig, seg, exp_seg, busy, exp_busy);
      end
      if (i >= 20) begin
        for (int b = 0; b < 6; b++) begin
          if (dig_en == 6'(1 << b)) begin
            seen[b] = 1'b1;
            checks++;
            if (seg !== want[b]) begin
              errors++;
              $display("FAIL digit_123456 bit=%0d seg=%h want %h", b, seg, want[b]);
            end
          end
        end
      end
    end
    checks++;
    if (seen !== 6'h3F) begin
      errors++;
      $display("FAIL scan_cover seen=%b want 111111", seen);
    end
  endtask

  task automatic test_load_ignored();
    do_load(63, 63, 63);
    for (int n = 1; n < 60; n++) begin
      if (n == 2) begin
        hour = 6'd1; minute = 6'd2; second = 6'd3; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
      checks++;
      if (dig_en !== exp_dig || seg !== exp_seg || busy !== exp_busy) begin
        errors++;
        $display("FAIL load_ignored cyc=%0d dig_en=%b/%b seg=%h/%h busy=%b/%b", ecyc, dig_en, exp_dig, seg, exp_seg, busy, exp_busy);
      end
      if (n == 21 || n == 22) begin
        checks++;
        if (busy !== (n == 21)) begin
          errors++;
          $display("FAIL busy_latency n=%0d busy=%b want %b", n, busy, (n == 21));
        end
      end
      if (n > 23 && dig_en != 6'h00) begin
        checks++;
        if (seg !== ((dig_en & 6'b010101) != 0 ? 7'h4F : 7'h7D)) begin
          errors++;
          $display("FAIL digit_636363 dig_en=%b seg=%h", dig_en, seg);
        end
      end
    end
  endtask

  task automatic test_lzb();
    do_load(5, 0, 9);
    for (int n = 1; n < 40; n++) begin
      tick();
      checks++;
      if (dig_en !== exp_dig || seg !== exp_seg || busy !== exp_busy) begin
        errors++;
        $display("FAIL lzb cyc=%0d dig_en=%b/%b seg=%h/%h busy=%b/%b", ecyc, dig_en, exp_dig, seg, exp_seg, busy, exp_busy);
      end
      if (n > 6) begin
        checks++;
        if (dig_en[5] !== 1'b0) begin
          errors++;
          $display("FAIL lzb_dig5 dig_en=%b want bit5=0", dig_en);
        end
        if (dig_en == 6'b010000) begin
          checks++;
          if (seg !== 7'h6D) begin
            errors++;
            $display("FAIL lzb_hour_units seg=%h want 6d", seg);
          end
        end
      end
    end
  endtask

  task automatic test_blink();
    do_load(12, 34, 56);
    for (int i = 0; i < 16; i++) tick();
    finished = 1'b1; blink_en = 1'b1;
    for (int j = 0; j < 52; j++) begin
      tick();
      checks++;
      if (dig_en !== exp_dig || seg !== exp_seg || busy !== exp_busy) begin
        errors++;
        $display("FAIL blink cyc=%0d dig_en=%b/%b seg=%h/%h", ecyc, dig_en, exp_dig, seg, exp_seg);
      end
      if ((j / 16) % 2 == 1) begin
        checks++;
        if (dig_en !== 6'h00 || seg !== 7'h00) begin
          errors++;
          $display("FAIL blink_dark j=%0d dig_en=%b seg=%h want 000000/00", j, dig_en, seg);
        end
      end
    end
    finished = 1'b0;
    tick();
    checks++;
    if (dig_en === 6'h00 || dig_en !== exp_dig || seg !== exp_seg) begin
      errors++;
      $display("FAIL blink_release dig_en=%b/%b seg=%h/%h", dig_en, exp_dig, seg, exp_seg);
    end
    blink_en = 1'b0;
  endtask

  task automatic test_reset_midconv();
    do_load(45, 21, 38);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || dig_en !== 6'h00 || seg !== 7'h00) begin
      errors++;
      $display("FAIL midconv_reset busy=%b dig_en=%b seg=%h want 0/000000/00", busy, dig_en, seg);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (dig_en !== 6'b000001 || seg !== 7'h3F || busy !== 1'b0) begin
      errors++;
      $display("FAIL midconv_zero dig_en=%b seg=%h busy=%b want 000001/3f/0", dig_en, seg, busy);
    end
    do_load(27, 8, 59);
    for (int i = 0; i < 45; i++) begin
      tick();
      checks++;
      if (dig_en !== exp_dig || seg !== exp_seg || busy !== exp_busy) begin
        errors++;
        $display("FAIL midconv_reload cyc=%0d dig_en=%b/%b seg=%h/%h busy=%b/%b", ecyc, dig_en, exp_dig, seg, exp_seg, busy, exp_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 7) == 0);
      hour = 6'($urandom_range(0, 63));
      minute = 6'($urandom_range(0, 63));
      second = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 39) == 0) finished = ~finished;
      if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
      reset = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (dig_en !== exp_dig || seg !== exp_seg || busy !== exp_busy) begin
        errors++;
        $display("FAIL random cyc=%0d dig_en=%b/%b seg=%h/%h busy=%b/%b", ecyc, dig_en, exp_dig, seg, exp_seg, busy, exp_busy);
      end
    end
    reset = 1'b0; load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0;
    hour = '0; minute = '0; second = '0;
    finished = 1'b0; blink_en = 1'b0;
    test_reset();
    test_load_123456();
    test_load_ignored();
    test_lzb();
    test_blink();
    test_reset_midconv();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
